dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU M-stage and an external port (loader/debug/trigger
//  logic). Grants one requester per cycle. Stalls the pipeline while the CPU loses arbitration. Applies
//  starvation control and bounded external bus-lock. Sits between pip_reg_m outputs and data_memory.
// PARAMETERS
//  DATA_WIDTH    32  data bus width
//  ADDR_WIDTH    32  address width
//  STARVE_LIMIT  4   consecutive contended CPU wins before the external port is forced through (>=1)
//  LOCK_MAX      8   max consecutive external grants under ext_lock_i (>=1)
// PORTS
//  clk_i         in   1           clock
//  rst_i         in   1           synchronous reset, active-high
//  cpu_req_i     in   1           CPU M-stage access (load or store)
//  cpu_we_i      in   1           CPU store
//  cpu_addr_i    in   ADDR_WIDTH  CPU address (ALUResultM)
//  cpu_wdata_i   in   DATA_WIDTH  CPU store data (WriteDataM)
//  cpu_rdata_o   out  DATA_WIDTH  CPU load data, combinational
//  cpu_stall_o   out  1           freeze F/D/E/M stages this cycle
//  ext_req_i     in   1           external access; held stable until ext_gnt_o
//  ext_we_i      in   1           external write
//  ext_lock_i    in   1           request consecutive external grants
//  ext_addr_i    in   ADDR_WIDTH  external address
//  ext_wdata_i   in   DATA_WIDTH  external write data
//  ext_gnt_o     out  1           external access performed this cycle
//  ext_rvalid_o  out  1           ext_rdata_o valid (registered)
//  ext_rdata_o   out  DATA_WIDTH  external read data (registered)
//  mem_we_o      out  1           to data_memory wr_en_i
//  mem_addr_o    out  ADDR_WIDTH  to data_memory addr_i
//  mem_wdata_o   out  DATA_WIDTH  to data_memory data_i
//  mem_rdata_i   in   DATA_WIDTH  from data_memory data_o (combinational read)
// BEHAVIOUR
//  - Grant is combinational, same cycle. The lone requester always wins.
//  - Contention (both req): winner set by FSM state.
//  - FSM: CPU_PRI (reset state), EXT_FORCE, EXT_LOCK.
//  - CPU_PRI: CPU wins contention and starve_cnt++ (saturating).
//      starve_cnt reaches STARVE_LIMIT -> EXT_FORCE.
//      An external grant with ext_lock_i=1 -> EXT_LOCK, lock_cnt=1.
//  - EXT_FORCE: external wins contention.
//      On external grant -> EXT_LOCK (lock_cnt=1) if ext_lock_i=1, else CPU_PRI.
//      ext_req_i=0 -> CPU_PRI.
//  - EXT_LOCK: external wins contention; lock_cnt++ per external grant.
//      Exits to CPU_PRI when ext_lock_i=0, ext_req_i=0, or the grant that brings lock_cnt to LOCK_MAX.
//      After a LOCK_MAX exit, CPU wins the next contended cycle.
//  - starve_cnt clears on any external grant or any cycle with ext_req_i=0.
//  - lock_cnt clears on EXT_LOCK exit.
//  - cpu_stall_o = cpu_req_i & ~cpu_gnt. No stall when the CPU is idle.
//  - mem_* outputs carry the granted requester's we/addr/wdata. With no grant, all mem_* outputs are 0.
//  - cpu_rdata_o = mem_rdata_i every cycle; meaningful only when the CPU is granted a load.
//  - External read granted in cycle N: ext_rvalid_o=1 and ext_rdata_o=mem_rdata_i(N) in cycle N+1.
//    External writes never raise ext_rvalid_o.
//  - Reset (cycle rst_i=1): state=CPU_PRI, starve_cnt=0, lock_cnt=0, ext_rvalid_o=0, ext_rdata_o=0.
//    During reset: ext_gnt_o=0, cpu_stall_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
//    Reset mid-lock drops the lock; there is no pending-transaction replay.
// TESTING
//  1. CPU-only store addr 0x10 data 0xDEADBEEF -> mem_we_o=1 same cycle, cpu_stall_o=0, ext_gnt_o=0.
//  2. Ext-only read addr 0x20 (mem holds 0x1234) -> ext_gnt_o=1 cycle N; ext_rvalid_o=1,
//     ext_rdata_o=0x1234 cycle N+1.
//  3. Both requesting continuously, STARVE_LIMIT=4 -> CPU granted 4 cycles, ext granted cycle 5
//     with cpu_stall_o=1, CPU granted again cycle 6.
//  4. ext_lock_i=1, LOCK_MAX=8, both requesting -> 8 consecutive ext grants with cpu_stall_o=1,
//     then a CPU grant.
//  5. rst_i=1 in the middle of case 4 -> next cycle ext_rvalid_o=0, state CPU_PRI, CPU wins first contention.
//  6. Ext read granted, ext_req_i dropped next cycle -> ext_rvalid_o pulses exactly once; starve_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU M-stage and an external port.
// Same-cycle grant, starvation forcing for the external port, and bounded external bus-lock.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_MAX     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  cpu_stall_o,
  input  logic                  ext_req_i,
  input  logic                  ext_we_i,
  input  logic                  ext_lock_i,
  input  logic [ADDR_WIDTH-1:0] ext_addr_i,
  input  logic [DATA_WIDTH-1:0] ext_wdata_i,
  output logic                  ext_gnt_o,
  output logic                  ext_rvalid_o,
  output logic [DATA_WIDTH-1:0] ext_rdata_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {StCpuPri, StExtForce, StExtLock} state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [LW-1:0]         lock_q, lock_d;
  logic                  ext_rvalid_q, ext_rvalid_d;
  logic [DATA_WIDTH-1:0] ext_rdata_q, ext_rdata_d;

  logic contended;
  logic cpu_gnt;
  logic ext_gnt;
  logic lock_ok;

  // A single-grant lock window is no lock at all, so LOCK_MAX=1 never enters StExtLock.
  assign lock_ok = ext_lock_i && (LOCK_MAX > 1);

  always_comb begin
    contended = cpu_req_i & ext_req_i;
    cpu_gnt   = 1'b0;
    ext_gnt   = 1'b0;
    if (!rst_i) begin
      if (contended) begin
        ext_gnt = (state_q != StCpuPri);
        cpu_gnt = ~ext_gnt;
      end else begin
        cpu_gnt = cpu_req_i;
        ext_gnt = ext_req_i;
      end
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ext_gnt) begin
      mem_we_o    = ext_we_i;
      mem_addr_o  = ext_addr_i;
      mem_wdata_o = ext_wdata_i;
    end else if (cpu_gnt) begin
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end
  end

  assign ext_gnt_o    = ext_gnt;
  assign cpu_stall_o  = cpu_req_i & ~cpu_gnt & ~rst_i;
  assign cpu_rdata_o  = mem_rdata_i;
  assign ext_rvalid_o = ext_rvalid_q;
  assign ext_rdata_o  = ext_rdata_q;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lock_d   = lock_q;
    case (state_q)
      StCpuPri: begin
        if (contended) begin
          if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
          if (starve_d == SW'(STARVE_LIMIT)) state_d = StExtForce;
        end else if (ext_gnt) begin
          starve_d = '0;
          if (lock_ok) begin
            state_d = StExtLock;
            lock_d  = LW'(1);
          end
        end else if (!ext_req_i) begin
          starve_d = '0;
        end
      end
      StExtForce: begin
        // Here the external port is either granted or idle; both clear starvation.
        starve_d = '0;
        if (ext_gnt && lock_ok) begin
          state_d = StExtLock;
          lock_d  = LW'(1);
        end else begin
          state_d = StCpuPri;
          lock_d  = '0;
        end
      end
      StExtLock: begin
        starve_d = '0;
        if (ext_gnt && ext_lock_i && (lock_q + LW'(1) != LW'(LOCK_MAX))) begin
          lock_d = lock_q + LW'(1);
        end else begin
          state_d = StCpuPri;
          lock_d  = '0;
        end
      end
      default: begin
        state_d  = StCpuPri;
        starve_d = '0;
        lock_d   = '0;
      end
    endcase
  end

  always_comb begin
    ext_rvalid_d = ext_gnt & ~ext_we_i;
    ext_rdata_d  = ext_rvalid_d ? mem_rdata_i : ext_rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StCpuPri;
      starve_q     <= '0;
      lock_q       <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      lock_q       <= lock_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

endmodule
